// File: rtl/hamming_sec_scrubber.sv
// hamming_sec_scrubber: background Hamming-SEC scrubber sharing the memory's single port with the host.
// Define SCRUB_STATS_EN to implement err_count/last_err_addr; otherwise both read as 0.
module hamming_sec_scrubber #(
   parameter int ADDR_W         = 4,
   parameter int CODE_W         = 12,
   parameter int SCRUB_INTERVAL = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              scrub_en,
   input  logic              host_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wr_en,
   output logic [CODE_W-1:0] mem_wdata,
   input  logic [CODE_W-1:0] mem_rdata,
   output logic              scrub_active,
   output logic              pass_done,
   output logic              uncorr_flag,
   output logic [7:0]        err_count,
   output logic [ADDR_W-1:0] last_err_addr
);
   localparam int CNT_W = $clog2(SCRUB_INTERVAL + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCRUB_INTERVAL - 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ISSUE, S_READ, S_CHECK, S_WRITE, S_NEXT} state_t;
   state_t r_state, w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [CODE_W-1:0] r_rdata, r_corr, w_corr;
   logic [3:0]        w_syn;
   logic              r_uncorr, w_fix, w_own;
   always_comb begin
      w_syn = '0;
      for (int i = 0; i < CODE_W; i++)
         w_syn = w_syn ^ (r_rdata[i] ? 4'(i + 1) : 4'd0);
   end
   assign w_fix  = (w_syn != 4'd0) && (w_syn <= 4'(CODE_W));
   assign w_corr = w_fix ? r_rdata ^ (CODE_W'(1) << (w_syn - 4'd1)) : r_rdata;
   // Any host request outside ISSUE abandons the word; it is re-read since the host may have rewritten it.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = scrub_en ? S_WAIT : S_IDLE;
         S_WAIT:  w_next = !scrub_en ? S_IDLE : (r_cnt == CNT_LAST) ? S_ISSUE : S_WAIT;
         S_ISSUE: w_next = host_req ? S_ISSUE : S_READ;
         S_READ:  w_next = host_req ? S_ISSUE : S_CHECK;
         S_CHECK: w_next = host_req ? S_ISSUE : w_fix ? S_WRITE : S_NEXT;
         S_WRITE: w_next = host_req ? S_ISSUE : S_NEXT;
         S_NEXT:  w_next = !scrub_en ? S_IDLE : (r_addr == ADDR_LAST) ? S_WAIT : S_ISSUE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_addr   <= '0;
         r_rdata  <= '0;
         r_corr   <= '0;
         r_uncorr <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (r_state == S_WAIT) ? r_cnt + 1'b1 : '0;
         r_addr  <= (r_state == S_WAIT) ? '0 : (r_state == S_NEXT) ? r_addr + 1'b1 : r_addr;
         if (r_state == S_READ && !host_req)
            r_rdata <= mem_rdata;
         if (r_state == S_CHECK && !host_req)
            r_corr <= w_corr;
         if (r_state == S_CHECK && !host_req && w_syn > 4'(CODE_W))
            r_uncorr <= 1'b1;
      end
   end
   assign w_own        = (r_state == S_ISSUE) || (r_state == S_READ) || (r_state == S_CHECK) || (r_state == S_WRITE);
   assign scrub_active = w_own && !host_req;
   assign mem_wr_en    = (r_state == S_WRITE) && !host_req;
   assign mem_addr     = r_addr;
   assign mem_wdata    = r_corr;
   assign pass_done    = (r_state == S_NEXT) && (r_addr == ADDR_LAST);
   assign uncorr_flag  = r_uncorr;
`ifdef SCRUB_STATS_EN
   logic [7:0]        r_err_count;
   logic [ADDR_W-1:0] r_last_err_addr;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_err_count     <= '0;
         r_last_err_addr <= '0;
      end else if (mem_wr_en) begin
         r_err_count     <= (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;
         r_last_err_addr <= r_addr;
      end
   end
   assign err_count     = r_err_count;
   assign last_err_addr = r_last_err_addr;
`else
   assign err_count     = '0;
   assign last_err_addr = '0;
`endif
endmodule

// File: tb/tb_hamming_sec_scrubber.sv
// tb_hamming_sec_scrubber: directed + randomized checks of the scrubber against a Hamming reference model.
// Expectations for err_count/last_err_addr follow whether SCRUB_STATS_EN is defined.
module tb_hamming_sec_scrubber;
`ifdef SCRUB_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   logic        clk = 0, rst = 0, scrub_en = 0, host_req = 0, host_we = 0;
   logic [3:0]  host_addr = 0, mem_addr, last_err_addr;
   logic [11:0] host_wdata = 0, mem_wdata, mem_rdata = 0;
   logic        mem_wr_en, scrub_active, pass_done, uncorr_flag;
   logic [7:0]  err_count;
   logic [11:0] mem [16];
   logic [11:0] gold [16];
   int          wr_cnt [16];
   int          wr_total = 0, total = 0, bad = 0;
   hamming_sec_scrubber #(.ADDR_W(4), .CODE_W(12), .SCRUB_INTERVAL(4)) dut (
      .clk(clk), .rst(rst), .scrub_en(scrub_en), .host_req(host_req),
      .mem_addr(mem_addr), .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .scrub_active(scrub_active), .pass_done(pass_done), .uncorr_flag(uncorr_flag),
      .err_count(err_count), .last_err_addr(last_err_addr));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   // Single-port memory with registered read; the scrubber owns the port whenever scrub_active is high.
   always @(posedge clk) begin
      if (mem_wr_en) begin
         chk("wr_with_host_req", {31'd0, host_req}, 0);
         mem[mem_addr] = mem_wdata;
         wr_cnt[mem_addr] = wr_cnt[mem_addr] + 1;
         wr_total = wr_total + 1;
      end else if (host_req && host_we)
         mem[host_addr] = host_wdata;
      mem_rdata <= mem[scrub_active ? mem_addr : host_addr];
   end
   function automatic logic [11:0] enc(input logic [7:0] d);
      logic [11:0] w = '0;
      int k = 0;
      for (int pos = 1; pos <= 12; pos++)
         if ((pos & (pos - 1)) != 0) begin
            w[pos-1] = d[k];
            k++;
         end
      for (int p = 1; p <= 8; p *= 2)
         for (int pos = 1; pos <= 12; pos++)
            if ((pos & p) != 0 && pos != p) w[p-1] = w[p-1] ^ w[pos-1];
      return w;
   endfunction
   function automatic logic [31:0] exp_cnt(input int n);
      return STATS ? ((n > 255) ? 255 : n) : 0;
   endfunction
   task automatic host_write(input int a, input logic [11:0] d);
      host_req = 1; host_we = 1; host_addr = 4'(a); host_wdata = d;
      @(posedge clk); #1;
      host_req = 0; host_we = 0;
   endtask
   task automatic wait_done(input string tag);
      int n = 0;
      while (pass_done !== 1'b1 && n < 3000) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_done"}, {31'd0, pass_done}, 1);
      scrub_en = 0;
      @(posedge clk); #1;
      chk({tag, "_pulse_end"}, {31'd0, pass_done}, 0);
   endtask
   task automatic run_pass(input string tag);
      scrub_en = 1;
      wait_done(tag);
   endtask
   function automatic int mem_bad();
      int m = 0;
      for (int a = 0; a < 16; a++) if (mem[a] !== gold[a]) m++;
      return m;
   endfunction
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      int ncorr, cyc, w0, w_a, left, n_this, last_a;
      logic [11:0] bad_w;
      for (int a = 0; a < 16; a++) wr_cnt[a] = 0;
      ncorr = 0;
      #12;
      chk("rst_wr_en", {31'd0, mem_wr_en}, 0);
      chk("rst_active", {31'd0, scrub_active}, 0);
      chk("rst_pass_done", {31'd0, pass_done}, 0);
      chk("rst_uncorr", {31'd0, uncorr_flag}, 0);
      chk("rst_err_count", {24'd0, err_count}, 0);
      chk("rst_last_addr", {28'd0, last_err_addr}, 0);
      chk("rst_addr", {28'd0, mem_addr}, 0);
      @(posedge clk); #1;
      rst = 1;
      for (int a = 0; a < 16; a++) begin
         gold[a] = enc(8'($urandom));
         host_write(a, gold[a]);
      end
      // clean pass: 4 idle-interval cycles + 16 words x 4 cycles
      w0 = wr_total;
      scrub_en = 1;
      @(posedge clk); #1;
      cyc = 1;
      while (pass_done !== 1'b1 && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("first_pass_cycles", cyc, 68);
      scrub_en = 0;
      @(posedge clk); #1;
      chk("clean_no_writes", wr_total - w0, 0);
      chk("clean_err_count", {24'd0, err_count}, exp_cnt(0));
      // single-bit error at addr 5
      gold[5] = enc(8'hA5);
      host_write(5, gold[5] ^ 12'h040);
      w0 = wr_total; w_a = wr_cnt[5];
      run_pass("a5");
      ncorr++;
      chk("a5_writes_total", wr_total - w0, 1);
      chk("a5_writes_addr", wr_cnt[5] - w_a, 1);
      chk("a5_mem", {20'd0, mem[5]}, {20'd0, gold[5]});
      chk("a5_err_count", {24'd0, err_count}, exp_cnt(ncorr));
      chk("a5_last_addr", {28'd0, last_err_addr}, STATS ? 5 : 0);
      w0 = wr_total;
      run_pass("a5_again");
      chk("a5_second_pass_writes", wr_total - w0, 0);
      // syndrome 14: positions 2,4,8 flipped on a valid word
      bad_w = gold[9] ^ 12'h08A;
      host_write(9, bad_w);
      w0 = wr_total;
      run_pass("syn14");
      chk("syn14_no_write", wr_total - w0, 0);
      chk("syn14_uncorr", {31'd0, uncorr_flag}, 1);
      chk("syn14_mem_kept", {20'd0, mem[9]}, {20'd0, bad_w});
      run_pass("syn14_again");
      chk("syn14_uncorr_sticky", {31'd0, uncorr_flag}, 1);
      host_write(9, gold[9]);
      // host preempts the CHECK of corrupted addr 3
      host_write(3, gold[3] ^ 12'h800);
      w0 = wr_total; w_a = wr_cnt[3];
      scrub_en = 1;
      cyc = 0;
      while (!(scrub_active === 1'b1 && mem_addr === 4'd3) && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("a3_issue_seen", {31'd0, scrub_active}, 1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      host_req = 1; host_we = 0; host_addr = 4'd3;
      #1;
      chk("a3_host_no_wr", {31'd0, mem_wr_en}, 0);
      chk("a3_host_inactive", {31'd0, scrub_active}, 0);
      @(posedge clk); #1;
      host_req = 0;
      #1;
      chk("a3_reissue_active", {31'd0, scrub_active}, 1);
      chk("a3_reissue_addr", {28'd0, mem_addr}, 3);
      wait_done("a3");
      ncorr++;
      chk("a3_writes_addr", wr_cnt[3] - w_a, 1);
      chk("a3_writes_total", wr_total - w0, 1);
      chk("a3_mem", {20'd0, mem[3]}, {20'd0, gold[3]});
      chk("a3_err_count", {24'd0, err_count}, exp_cnt(ncorr));
      // reset asserted while a correction write is on the port
      host_write(7, gold[7] ^ 12'h010);
      w_a = wr_cnt[7];
      scrub_en = 1;
      cyc = 0;
      while (mem_wr_en !== 1'b1 && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("a7_write_seen", {31'd0, mem_wr_en}, 1);
      rst = 0;
      #1;
      chk("rstw_wr_en", {31'd0, mem_wr_en}, 0);
      chk("rstw_active", {31'd0, scrub_active}, 0);
      chk("rstw_err_count", {24'd0, err_count}, 0);
      chk("rstw_last_addr", {28'd0, last_err_addr}, 0);
      chk("rstw_uncorr", {31'd0, uncorr_flag}, 0);
      @(posedge clk); #1;
      chk("rstw_no_write", wr_cnt[7] - w_a, 0);
      rst = 1;
      ncorr = 0;
      cyc = 0;
      while (scrub_active !== 1'b1 && cyc < 500) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("restart_addr0", {28'd0, mem_addr}, 0);
      wait_done("a7");
      ncorr++;
      chk("a7_writes_addr", wr_cnt[7] - w_a, 1);
      chk("a7_mem", {20'd0, mem[7]}, {20'd0, gold[7]});
      chk("a7_err_count", {24'd0, err_count}, exp_cnt(ncorr));
      chk("a7_last_addr", {28'd0, last_err_addr}, STATS ? 7 : 0);
      // 300 random single-bit flips spread over passes; count saturates at 255
      left = 300;
      last_a = 0;
      while (left > 0) begin
         n_this = 0;
         for (int a = 0; a < 16 && left > 0; a++) begin
            host_write(a, gold[a] ^ (12'd1 << $urandom_range(0, 11)));
            left--; n_this++; ncorr++; last_a = a;
         end
         w0 = wr_total;
         run_pass("flips");
         chk("flips_writes", wr_total - w0, n_this);
         chk("flips_mem_clean", mem_bad(), 0);
         chk("flips_err_count", {24'd0, err_count}, exp_cnt(ncorr));
      end
      chk("sat_err_count", {24'd0, err_count}, STATS ? 255 : 0);
      chk("sat_last_addr", {28'd0, last_err_addr}, STATS ? last_a : 0);
      chk("sat_uncorr_clear", {31'd0, uncorr_flag}, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/hamming_sec_scrubber.md
# hamming_sec_scrubber

Background scrubber for the Hamming-SEC-protected 16 x 12-bit codeword memory. It walks every address, reads the stored codeword and recomputes the syndrome. On a single-bit error it writes the corrected codeword back, so that a later second flip cannot accumulate into an uncorrectable word. It shares the memory's single port with the host path and always yields to it; it writes what the encoder/read path only ever reads.

## Interface
Parameters:
- ADDR_W, 4, memory address width (depth = 2^ADDR_W)
- CODE_W, 12, codeword width (fixed Hamming SEC layout; only 12 is supported)
- SCRUB_INTERVAL, 256, idle cycles between the end of one pass and the start of the next (min 1)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- scrub_en  in  1  level; enables scrubbing passes
- host_req  in  1  host owns the memory port this cycle; scrubber must not drive
- mem_addr  out  ADDR_W  scrubber address to memory mux
- mem_wr_en  out  1  scrubber write strobe
- mem_wdata  out  CODE_W  corrected codeword
- mem_rdata  in  CODE_W  memory read data, valid one cycle after the address is presented
- scrub_active  out  1  scrubber owns the port (mux select)
- pass_done  out  1  one-cycle pulse after the last address of a pass
- uncorr_flag  out  1  sticky; syndrome 13–15 seen; cleared only by reset
- err_count  out  8  corrected-error count, saturating at 255
- last_err_addr  out  ADDR_W  address of most recent correction

## Operation
- Codeword layout: bit i holds Hamming position i+1. Parity bits are at positions 1, 2, 4, 8. Data d0..d7 are at positions 3, 5, 6, 7, 9, 10, 11, 12.
- Syndrome = XOR of the position numbers of all set bits; 0 means clean.
- For syndrome 1–12, the corrected word is mem_rdata with bit (syndrome-1) inverted.
- FSM states:
  - IDLE: scrub_en=1 → WAIT with interval counter cleared.
  - WAIT: counts SCRUB_INTERVAL cycles, then → ISSUE with addr=0.
  - ISSUE: requires host_req=0. Drives mem_addr, scrub_active=1, mem_wr_en=0, then → READ. If host_req=1, it stalls with scrub_active=0.
  - READ: captures mem_rdata → CHECK.
  - CHECK: registers the syndrome and the corrected word.
    - Syndrome 0 → NEXT.
    - Syndrome 1–12 → WRITE.
    - Syndrome 13–15 → set uncorr_flag, no write → NEXT.
  - WRITE: requires host_req=0. Drives mem_wr_en=1, mem_addr, and the corrected word for exactly one cycle. Updates err_count/last_err_addr, then → NEXT.
  - NEXT: at the last address, pulse pass_done and go to WAIT (scrub_en=1) or IDLE. Otherwise increment the address and go to ISSUE.
- Host preemption: if host_req=1 in READ, CHECK or WRITE, abandon the current word and return to ISSUE at the same address. The host may have rewritten it, so the word is re-read.
- scrub_en deasserted mid-pass: finish the current address (through NEXT), then IDLE; pass_done is not pulsed unless that address was the last.
- The address counter wraps from 2^ADDR_W-1 to 0 only via NEXT.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0. A reset mid-WRITE drops mem_wr_en asynchronously.
- Clean word: 4 cycles (ISSUE, READ, CHECK, NEXT).
- Corrected word: 5 cycles.
- Full clean pass: 64 cycles plus SCRUB_INTERVAL before it.
- mem_wr_en is never high in the same cycle as host_req.
- scrub_active=1 exactly in ISSUE/READ/CHECK/WRITE cycles where host_req=0.
- pass_done is high in the NEXT cycle of the last address.
- err_count saturates: a correction at 255 leaves the count at 255, but last_err_addr is still updated.

## Configuration
- SCRUB_STATS_EN defined: err_count and last_err_addr are implemented as specified.
- SCRUB_STATS_EN undefined: both outputs are tied to 0 and their registers are removed. Correction, uncorr_flag and pass_done are unchanged.

## Test plan
- All 16 words valid codewords, scrub_en=1, SCRUB_INTERVAL=4:
  - First pass_done 4+64 cycles after leaving IDLE.
  - mem_wr_en never asserted.
  - err_count=0.
- Addr 5 holds encoded 0xA5 with bit 6 flipped:
  - Exactly one write to addr 5 with the original codeword.
  - err_count=1, last_err_addr=5; a second pass makes no writes.
- Addr 9 word with syndrome 14 (positions 2, 4, 8 set over a valid word):
  - No write.
  - uncorr_flag=1 and stays set through later passes.
- host_req pulsed during CHECK of corrupted addr 3:
  - No write in that cycle.
  - Scrubber re-issues addr 3 and writes it once after host_req drops.
- rst low during WRITE:
  - mem_wr_en, scrub_active and counters go to 0 immediately.
  - After release, the scrubber restarts from IDLE at addr 0.
- Inject 300 single-bit flips across passes:
  - err_count saturates at 255.
  - With SCRUB_STATS_EN undefined, err_count stays 0 while corrections still occur.
